// File: rtl/vga_timing_pattern_gen.sv
// VGA timing master with built-in test patterns (bars, checker, ramp, flicker).
// Optional macro VGA_BORDER_EN draws a 1-pixel white frame around the active area.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 4,
  parameter int CNT_W    = 11
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [1:0]       pat_sel,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [CW-1:0]    vga_r,
  output logic [CW-1:0]    vga_g,
  output logic [CW-1:0]    vga_b,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ALAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ALAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_S    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_S    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_L   = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic             HS_ON   = (HS_POL != 0);
  localparam logic             VS_ON   = (VS_POL != 0);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar;
  logic [1:0]       pat;
  logic             parity;

  logic             h_last;
  logic             v_last;
  logic             de_n;
  logic             hs_n;
  logic             vs_n;
  logic             ls_n;
  logic             fs_n;
  logic [CW-1:0]    r_n;
  logic [CW-1:0]    g_n;
  logic [CW-1:0]    b_n;
  logic [CW-1:0]    full;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign full   = '1;

  always_comb begin
    de_n = (h < H_ACT) && (v < V_ACT);
    hs_n = (h >= HS_S && h < HS_E) ? HS_ON : ~HS_ON;
    vs_n = (v >= VS_S && v < VS_E) ? VS_ON : ~VS_ON;
    ls_n = de_n && (h == '0);
    fs_n = (h == '0) && (v == '0);
    r_n  = '0;
    g_n  = '0;
    b_n  = '0;
    case (pat)
      2'd0: begin
        r_n = bar[1] ? '0 : full;
        g_n = bar[2] ? '0 : full;
        b_n = bar[0] ? '0 : full;
      end
      2'd1: begin
        r_n = (h[5] ^ v[5]) ? full : '0;
        g_n = r_n;
        b_n = r_n;
      end
      2'd2: begin
        r_n = h[CW+3:4];
        g_n = h[CW+3:4];
        b_n = h[CW+3:4];
      end
      default: begin
        r_n = parity ? '0 : full;
        g_n = r_n;
        b_n = r_n;
      end
    endcase
`ifdef VGA_BORDER_EN
    if (h == '0 || h == H_ALAST || v == '0 || v == V_ALAST) begin
      r_n = full;
      g_n = full;
      b_n = full;
    end
`endif
    if (!de_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // bar index follows h via a reloading sub-counter instead of a divide
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      h           <= '0;
      v           <= '0;
      bar_cnt     <= '0;
      bar         <= '0;
      pat         <= '0;
      parity      <= 1'b0;
      vga_hs      <= ~HS_ON;
      vga_vs      <= ~VS_ON;
      vga_de      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (h_last) begin
        h       <= '0;
        bar_cnt <= '0;
        bar     <= '0;
        v       <= v_last ? '0 : v + ONE;
        if (v_last) begin
          pat    <= pat_sel;
          parity <= ~parity;
        end
      end else begin
        h <= h + ONE;
        if (bar_cnt == BAR_L) begin
          bar_cnt <= '0;
          bar     <= bar + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + ONE;
        end
      end
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_de      <= de_n;
      vga_r       <= r_n;
      vga_g       <= g_n;
      vga_b       <= b_n;
      pix_x       <= h;
      pix_y       <= v;
      line_start  <= ls_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Directed bench: one default-mode instance for line timing, one small mode
// (80x46 totals) for whole-frame, pattern and reset behaviour.
module tb_vga_timing_pattern_gen;

  localparam int HT = 80;
  localparam int VT = 46;
  localparam int FR = HT * VT;

  logic        clk_pix = 1'b0;
  logic        rst_n   = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [1:0]  def_pat = 2'd0;

  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [3:0]  d_r, d_g, d_b;
  logic [10:0] d_x, d_y;

  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0]  s_r, s_g, s_b;
  logic [10:0] s_x, s_y;

  int t;
  int checks = 0;
  int errors = 0;

  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  always #5 clk_pix = ~clk_pix;

  vga_timing_pattern_gen u_def (
    .clk_pix(clk_pix), .rst_n(rst_n), .pat_sel(def_pat),
    .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .pix_x(d_x), .pix_y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(0), .CW(4), .CNT_W(11)
  ) u_sm (
    .clk_pix(clk_pix), .rst_n(rst_n), .pat_sel(pat_sel),
    .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .pix_x(s_x), .pix_y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic tick();
    @(posedge clk_pix);
    #1;
    t++;
  endtask

  task automatic goto(input int target);
    while (t < target) tick();
  endtask

  function automatic int at(input int fr, input int x, input int y);
    return fr * FR + y * HT + x;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    pat_sel = 2'd0;
    repeat (3) tick();
    checks++;
    if ({s_hs, s_vs, s_de, s_ls, s_fs} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_sm_ctrl got %b want 01000",
               {s_hs, s_vs, s_de, s_ls, s_fs});
    end
    checks++;
    if ({s_r, s_g, s_b, s_x, s_y} !== 34'h0) begin
      errors++;
      $display("FAIL reset_sm_data got %h want 0",
               {s_r, s_g, s_b, s_x, s_y});
    end
    checks++;
    if ({d_hs, d_vs, d_de, d_ls, d_fs, d_r, d_g, d_b} !== {5'b11000, 12'h000}) begin
      errors++;
      $display("FAIL reset_def got %b want 11000 rgb 0",
               {d_hs, d_vs, d_de, d_ls, d_fs, d_r, d_g, d_b});
    end
    rst_n = 1'b1;
    tick();
    t = 0;
    checks++;
    if ({s_de, s_fs, s_ls, s_x, s_y, s_r, s_g, s_b} !== {3'b111, 22'h0, 12'hFFF}) begin
      errors++;
      $display("FAIL release_sm got de%b fs%b ls%b x%0d y%0d rgb%h want 1 1 1 0 0 fff",
               s_de, s_fs, s_ls, s_x, s_y, {s_r, s_g, s_b});
    end
    checks++;
    if ({d_de, d_fs, d_ls, d_x, d_y, d_r, d_g, d_b} !== {3'b111, 22'h0, 12'hFFF}) begin
      errors++;
      $display("FAIL release_def got de%b fs%b ls%b x%0d y%0d rgb%h want 1 1 1 0 0 fff",
               d_de, d_fs, d_ls, d_x, d_y, {d_r, d_g, d_b});
    end
  endtask

  task automatic test_line_timing();
    int hs_first = -1;
    int hs_low   = 0;
    int de_cnt   = 0;
    int bad_blank = 0;
    int sh_first = -1;
    int sh_cnt   = 0;
    int x;
    logic [11:0] want;
    for (int n = 0; n <= 1600; n++) begin
      if (n > 0) tick();
      if (n < 800) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = n;
        end
        if (d_de) de_cnt++;
      end
      if (!d_de && {d_r, d_g, d_b} != 12'h0) bad_blank++;
      if (!s_de && {s_r, s_g, s_b} != 12'h0) bad_blank++;
      if (n < 80 && s_hs) begin
        sh_cnt++;
        if (sh_first < 0) sh_first = n;
      end
      if (n == 800) begin
        checks++;
        if ({d_ls, d_x, d_y} !== {1'b1, 11'd0, 11'd1}) begin
          errors++;
          $display("FAIL def_line2_start got ls%b x%0d y%0d want 1 0 1",
                   d_ls, d_x, d_y);
        end
      end
      x = n - 800;
      if (x == 0 || x == 80 || x == 160 || x == 560) begin
        want = bars[x / 80];
        checks++;
        if ({d_r, d_g, d_b} !== want) begin
          errors++;
          $display("FAIL def_bar_x%0d got %h want %h", x, {d_r, d_g, d_b}, want);
        end
      end
      if (x >= 8 && x < 64 && x % 8 == 0) begin
        want = bars[x / 8];
        checks++;
        if ({s_r, s_g, s_b} !== want) begin
          errors++;
          $display("FAIL sm_bar_x%0d got %h want %h", x, {s_r, s_g, s_b}, want);
        end
      end
    end
    checks++;
    if (hs_first !== 656 || hs_low !== 96) begin
      errors++;
      $display("FAIL def_hsync got first %0d width %0d want 656 96", hs_first, hs_low);
    end
    checks++;
    if (de_cnt !== 640) begin
      errors++;
      $display("FAIL def_de_count got %0d want 640", de_cnt);
    end
    checks++;
    if (sh_first !== 68 || sh_cnt !== 8) begin
      errors++;
      $display("FAIL sm_hsync got first %0d width %0d want 68 8", sh_first, sh_cnt);
    end
    checks++;
    if (bad_blank !== 0) begin
      errors++;
      $display("FAIL blank_rgb got %0d nonzero blank cycles want 0", bad_blank);
    end
  endtask

  task automatic test_vsync_and_hold();
    int vs_first = -1;
    int vs_cnt = 0;
    pat_sel = 2'd1;
    while (t < FR - 1) begin
      tick();
      if (!s_vs) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t;
      end
      if (t == at(0, 16, 20)) begin
        checks++;
        if ({s_r, s_g, s_b} !== 12'h0FF) begin
          errors++;
          $display("FAIL hold_bars got %h want 0ff", {s_r, s_g, s_b});
        end
      end
    end
    checks++;
    if (vs_first !== 3360 || vs_cnt !== 160) begin
      errors++;
      $display("FAIL sm_vsync got first %0d width %0d want 3360 160", vs_first, vs_cnt);
    end
  endtask

  task automatic test_checker_frame();
    int ls_cnt = 0;
    int ls_prev = -1;
    int ls_bad = 0;
    int fs_cnt = 0;
    int de_cnt = 0;
    logic [11:0] w00;
`ifdef VGA_BORDER_EN
    w00 = 12'hFFF;
`else
    w00 = 12'h000;
`endif
    while (t < 2 * FR - 1) begin
      tick();
      if (t == FR + 100) pat_sel = 2'd2;
      if (s_ls) begin
        ls_cnt++;
        if (ls_prev >= 0 && t - ls_prev != HT) ls_bad++;
        ls_prev = t;
      end
      if (s_fs) begin
        fs_cnt++;
        if (t != FR) ls_bad++;
      end
      if (s_de) de_cnt++;
      if (t == at(1, 0, 0)) begin
        checks++;
        if ({s_r, s_g, s_b} !== w00) begin
          errors++;
          $display("FAIL chk_0_0 got %h want %h", {s_r, s_g, s_b}, w00);
        end
      end
      if (t == at(1, 32, 0)) begin
        checks++;
        if ({s_r, s_g, s_b} !== 12'hFFF) begin
          errors++;
          $display("FAIL chk_32_0 got %h want fff", {s_r, s_g, s_b});
        end
      end
      if (t == at(1, 32, 32)) begin
        checks++;
        if ({s_r, s_g, s_b} !== 12'h000) begin
          errors++;
          $display("FAIL chk_32_32 got %h want 000", {s_r, s_g, s_b});
        end
      end
      if (t == at(1, 1, 1)) begin
        checks++;
        if ({s_r, s_g, s_b} !== 12'h000) begin
          errors++;
          $display("FAIL chk_1_1 got %h want 000", {s_r, s_g, s_b});
        end
      end
    end
    checks++;
    if (ls_cnt !== 40 || fs_cnt !== 1 || ls_bad !== 0 || de_cnt !== 2560) begin
      errors++;
      $display("FAIL frame_counts got ls%0d fs%0d bad%0d de%0d want 40 1 0 2560",
               ls_cnt, fs_cnt, ls_bad, de_cnt);
    end
    tick();
    checks++;
    if ({s_fs, s_x, s_y} !== {1'b1, 22'h0}) begin
      errors++;
      $display("FAIL next_frame_start got fs%b x%0d y%0d want 1 0 0", s_fs, s_x, s_y);
    end
  endtask

  task automatic test_grey();
    int xs [6] = '{0, 17, 32, 48, 63, 70};
    logic [11:0] ws [6] = '{12'h000, 12'h111, 12'h222, 12'h333, 12'h333, 12'h000};
`ifdef VGA_BORDER_EN
    ws[0] = 12'hFFF;
    ws[4] = 12'hFFF;
`endif
    for (int i = 0; i < 6; i++) begin
      goto(at(2, xs[i], 5));
      checks++;
      if ({s_r, s_g, s_b} !== ws[i] || s_de !== (xs[i] < 64)) begin
        errors++;
        $display("FAIL grey_x%0d got rgb %h de %b want %h %b",
                 xs[i], {s_r, s_g, s_b}, s_de, ws[i], xs[i] < 64);
      end
    end
    pat_sel = 2'd3;
  endtask

  task automatic test_flicker();
    logic [11:0] wc;
`ifdef VGA_BORDER_EN
    wc = 12'hFFF;
`else
    wc = 12'h000;
`endif
    goto(at(3, 10, 10));
    checks++;
    if ({s_r, s_g, s_b} !== 12'h000) begin
      errors++;
      $display("FAIL flicker_odd got %h want 000", {s_r, s_g, s_b});
    end
    goto(at(3, 63, 39));
    checks++;
    if ({s_de, s_x, s_y, s_r, s_g, s_b} !== {1'b1, 11'd63, 11'd39, wc}) begin
      errors++;
      $display("FAIL last_pixel got de%b x%0d y%0d rgb%h want 1 63 39 %h",
               s_de, s_x, s_y, {s_r, s_g, s_b}, wc);
    end
    goto(at(4, 10, 10));
    checks++;
    if ({s_r, s_g, s_b} !== 12'hFFF) begin
      errors++;
      $display("FAIL flicker_even got %h want fff", {s_r, s_g, s_b});
    end
  endtask

  task automatic test_reset_midline();
    goto(at(4, 30, 20));
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({s_hs, s_vs, s_de, s_ls, s_fs, s_r, s_g, s_b, s_x, s_y} !== {5'b01000, 34'h0}) begin
        errors++;
        $display("FAIL midreset_c%0d got hs%b vs%b de%b x%0d y%0d rgb%h want 0 1 0 0 0 0",
                 i, s_hs, s_vs, s_de, s_x, s_y, {s_r, s_g, s_b});
      end
    end
    rst_n   = 1'b1;
    pat_sel = 2'd1;
    tick();
    t = 0;
    checks++;
    if ({s_de, s_fs, s_ls, s_x, s_y, s_r, s_g, s_b} !== {3'b111, 22'h0, 12'hFFF}) begin
      errors++;
      $display("FAIL restart got de%b fs%b ls%b x%0d y%0d rgb%h want 1 1 1 0 0 fff",
               s_de, s_fs, s_ls, s_x, s_y, {s_r, s_g, s_b});
    end
  endtask

  task automatic test_border();
    logic [11:0] w05;
`ifdef VGA_BORDER_EN
    w05 = 12'hFFF;
`else
    w05 = 12'h000;
`endif
    goto(at(1, 0, 5));
    checks++;
    if ({s_r, s_g, s_b} !== w05) begin
      errors++;
      $display("FAIL border_0_5 got %h want %h", {s_r, s_g, s_b}, w05);
    end
    goto(at(1, 1, 5));
    checks++;
    if ({s_r, s_g, s_b} !== 12'h000) begin
      errors++;
      $display("FAIL inner_1_5 got %h want 000", {s_r, s_g, s_b});
    end
    goto(at(1, 32, 5));
    checks++;
    if ({s_r, s_g, s_b} !== 12'hFFF) begin
      errors++;
      $display("FAIL inner_32_5 got %h want fff", {s_r, s_g, s_b});
    end
  endtask

  initial begin
    t = 0;
    test_reset();
    test_line_timing();
    test_vsync_and_hold();
    test_checker_frame();
    test_grey();
    test_flicker();
    test_reset_midline();
    test_border();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised VGA timing generator with built-in test-pattern source. It drives sync, data-enable, pixel coordinates and multi-bit RGB from a single pixel clock. Display timing is set entirely by parameters, so one block covers 640x480, 800x600 and other modes. It sits between the pixel-clock PLL and the DAC/pin drivers, and serves as bring-up source and timing master for later framebuffer blocks.

Parameters:
H_ACTIVE, 640, visible pixels per line; must be a multiple of 8
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of vga_hs (0 = active-low)
VS_POL, 0, asserted level of vga_vs
CW, 4, bits per colour channel; CW+4 <= CNT_W
CNT_W, 11, width of the h/v counters and coordinates; must hold H_TOTAL-1

Ports:
clk_pix  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
pat_sel  in  2  pattern select; sampled only at frame boundary
vga_hs  out  1  horizontal sync, polarity per HS_POL
vga_vs  out  1  vertical sync, polarity per VS_POL
vga_de  out  1  active-video enable
vga_r  out  CW  red
vga_g  out  CW  green
vga_b  out  CW  blue
pix_x  out  CNT_W  column of current output pixel (valid when vga_de=1)
pix_y  out  CNT_W  line of current output pixel (valid when vga_de=1)
line_start  out  1  1-cycle pulse on first active pixel of each visible line
frame_start  out  1  1-cycle pulse on pixel (0,0) of each frame

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (800/525 at defaults).
- Horizontal counter h counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v increments only on the cycle h wraps; v counts 0..V_TOTAL-1, then wraps to 0. There are exactly H_TOTAL*V_TOTAL clocks per frame.
- Reset: h=v=0; pattern register=0; frame parity=0.
- Output values during reset: vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, rgb=0, pix_x=pix_y=0, line_start=frame_start=0.
- Reset asserted mid-frame aborts the frame. The first edge with rst_n=1 restarts at (0,0).
- All outputs are registered, with one-clock latency: outputs after edge n reflect counter state (h,v) held before edge n. The first edge with rst_n=1 presents (0,0): de=1, frame_start=1, line_start=1.
- de = (h < H_ACTIVE) and (v < V_ACTIVE).
- hs asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vs asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vs changes only together with the h wrap.
- line_start = de and h==0. frame_start = (h==0 and v==0).
- Pattern select: pat_sel is captured into the pattern register on the cycle h==H_TOTAL-1 and v==V_TOTAL-1. There is no mid-frame change. The frame parity bit toggles on the same cycle.
- rgb = 0 whenever de=0, regardless of pattern. "Full" means all CW bits set.
- Pattern 0, colour bars: 8 bars, each H_ACTIVE/8 wide. Bar index k is tracked by a sub-counter with no divider. R = full if ~k[1], G = full if ~k[2], B = full if ~k[0]. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- Pattern 1, checkerboard: 32x32 cells; white if h[5]^v[5], else black.
- Pattern 2, grey ramp: r = g = b = h[CW+3:4]. Level steps every 16 pixels and wraps.
- Pattern 3, flicker: full white on even-parity frames, black on odd-parity frames.

Optional Feature:
VGA_BORDER_EN:
- Defined: pixels with h==0, h==H_ACTIVE-1, v==0 or v==V_ACTIVE-1 (inside active area) are forced to full white, overriding the pattern. Latency is unchanged.
- Undefined: no override; the pattern is shown edge to edge.

Test Plan:
- Defaults, reset released: frame_start pulses every 420000 clocks; line_start pulses 480 times per frame, 800 clocks apart; de high 640 clocks per line.
- Defaults: vga_hs low for exactly 96 clocks, falling 656 clocks after line_start. vga_vs low for exactly 1600 clocks, asserting when v becomes 490 (with the h wrap).
- pat_sel=0, CW=4: at pix_x 0, 80, 160, 560, rgb = (F,F,F), (F,F,0), (0,F,F), (0,0,0). rgb=0 at every de=0 cycle.
- Change pat_sel 0->1 mid-frame: current frame stays bars. Next frame is checkerboard: (x=0,y=0)=black, (x=32,y=0)=white, (x=32,y=32)=black.
- pat_sel=3: consecutive frames alternate white/black; pix_x/pix_y at (639,479) equal 639/479.
- rst_n low for 3 clocks mid-line at v=200: outputs take reset values. First edge after release shows de=1, frame_start=1, pix_x=pix_y=0. With VGA_BORDER_EN and pat_sel=1, pixel (0,5) is white.
